// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID-stage hazard controller and the pipeline registers it steers.
// CNT_W here must match the controller's CNT_W.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs2;
   logic             idex_memread;
   logic [4:0]       idex_rd;
   logic             branch_taken;
   logic             mem_busy;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs2, idex_memread, idex_rd, branch_taken, mem_busy,
      input  pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs2, idex_memread, idex_rd, branch_taken, mem_busy,
      output pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use interlock, taken-branch flush and memory-busy freeze for the 5-stage core,
// with saturating stall/flush cycle counters.
module hazard_stall_ctrl #(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   hazard_stall_ctrl_if.slave hz
);
   typedef enum logic {RUN, LSTALL} state_t;

   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);

   state_t           state_q, state_d;
   logic [2:0]       dcnt_q, dcnt_d;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             hazard;
   logic             stall_inc, flush_inc;
   logic             pc_en, ifid_en, idex_en, ifid_flush, idex_bubble;

   assign hazard = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                   ((hz.idex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.idex_rd == hz.id_rs2)));

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      if (!rst_n) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (hz.mem_busy) begin
         // freeze holds everything, including the bubble budget
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_en   = 1'b0;
         stall_inc = 1'b1;
      end else if (hz.branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_inc   = 1'b1;
         state_d     = RUN;
         dcnt_d      = 3'd0;
      end else if (state_q == LSTALL || hazard) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         if (state_q == LSTALL) begin
            dcnt_d = dcnt_q - 3'd1;
            if (dcnt_q == 3'd1) state_d = RUN;
         end else if (LOAD_STALL > 1) begin
            state_d = LSTALL;
            dcnt_d  = STALL_RELOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         dcnt_q  <= 3'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
         if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
      end
   end

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid_en;
   assign hz.idex_en     = idex_en;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.stall_cnt   = stall_q;
   assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Three controllers (LOAD_STALL=1, LOAD_STALL=3, LOAD_STALL=2/CNT_W=4) share one stimulus
// stream and are checked against a bubbles-remaining reference model.
module tb_hazard_stall_ctrl;
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use2;
      logic       mr;
      logic [4:0] rd;
      logic       br;
      logic       mb;
   } stim_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b1;
   stim_t cur = '0;
   int    total = 0;
   int    bad = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.CNT_W(16)) if1 ();
   hazard_stall_ctrl_if #(.CNT_W(16)) if3 ();
   hazard_stall_ctrl_if #(.CNT_W(4))  if2 ();

   hazard_stall_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1.slave));
   hazard_stall_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut3 (.clk(clk), .rst_n(rst_n), .hz(if3.slave));
   hazard_stall_ctrl #(.LOAD_STALL(2), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .hz(if2.slave));

   assign {if1.id_rs1, if1.id_rs2, if1.id_uses_rs2, if1.idex_memread, if1.idex_rd, if1.branch_taken, if1.mem_busy} = cur;
   assign {if3.id_rs1, if3.id_rs2, if3.id_uses_rs2, if3.idex_memread, if3.idex_rd, if3.branch_taken, if3.mem_busy} = cur;
   assign {if2.id_rs1, if2.id_rs2, if2.id_uses_rs2, if2.idex_memread, if2.idex_rd, if2.branch_taken, if2.mem_busy} = cur;

   // {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble}
   logic [4:0]  ctl [3];
   logic [15:0] gs [3];
   logic [15:0] gf [3];
   assign ctl[0] = {if1.pc_en, if1.ifid_en, if1.idex_en, if1.ifid_flush, if1.idex_bubble};
   assign ctl[1] = {if3.pc_en, if3.ifid_en, if3.idex_en, if3.ifid_flush, if3.idex_bubble};
   assign ctl[2] = {if2.pc_en, if2.ifid_en, if2.idex_en, if2.ifid_flush, if2.idex_bubble};
   assign gs[0] = if1.stall_cnt;
   assign gf[0] = if1.flush_cnt;
   assign gs[1] = if3.stall_cnt;
   assign gf[1] = if3.flush_cnt;
   assign gs[2] = {12'd0, if2.stall_cnt};
   assign gf[2] = {12'd0, if2.flush_cnt};

   // Reference model: rem = bubbles still owed after the current one.
   int ml [3] = '{1, 3, 2};
   int mx [3] = '{65535, 65535, 15};
   int rem [3];
   int ms [3];
   int mf [3];

   function automatic bit haz(stim_t s);
      return s.mr && s.rd != 0 && (s.rd == s.rs1 || (s.use2 && s.rd == s.rs2));
   endfunction

   function automatic int sat(int v, int m);
      return (v >= m) ? m : v + 1;
   endfunction

   function automatic logic [4:0] exp_ctl(int k);
      if (!rst_n) return 5'b00011;
      if (cur.mb) return 5'b00000;
      if (cur.br) return 5'b11111;
      if (rem[k] > 0 || haz(cur)) return 5'b00101;
      return 5'b11100;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            rem[k] <= 0;
            ms[k]  <= 0;
            mf[k]  <= 0;
         end else if (cur.mb) begin
            ms[k] <= sat(ms[k], mx[k]);
         end else if (cur.br) begin
            mf[k]  <= sat(mf[k], mx[k]);
            rem[k] <= 0;
         end else if (rem[k] > 0 || haz(cur)) begin
            ms[k]  <= sat(ms[k], mx[k]);
            rem[k] <= (rem[k] > 0) ? rem[k] - 1 : ml[k] - 1;
         end
      end
   end

   function automatic stim_t mk(int rs1, int rs2, bit use2, bit mr, int rd, bit br, bit mb);
      stim_t s;
      s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.use2 = use2; s.mr = mr;
      s.rd = 5'(rd); s.br = br; s.mb = mb;
      return s;
   endfunction

   task automatic do_reset();
      cur = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      cur = mk(5, 0, 0, 1, 5, 0, 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (ctl[k] !== 5'b00011 || gs[k] !== 16'd0 || gf[k] !== 16'd0) begin
            bad++;
            $display("FAIL reset dut%0d got ctl=%b s=%0d f=%0d exp ctl=00011 s=0 f=0", k, ctl[k], gs[k], gf[k]);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      stim_t seq [4];
      int    low0 = 0;
      seq = '{mk(5, 0, 0, 1, 5, 0, 0), mk(5, 0, 0, 0, 5, 0, 0), '0, '0};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         cur = seq[c];
         @(negedge clk);
         if (ctl[0][4] == 1'b0) low0++;
         for (int k = 0; k < 3; k++) begin
            total++;
            if (ctl[k] !== exp_ctl(k) || gs[k] !== 16'(ms[k]) || gf[k] !== 16'(mf[k])) begin
               bad++;
               $display("FAIL load_use dut%0d cyc%0d got ctl=%b s=%0d f=%0d exp ctl=%b s=%0d f=%0d",
                        k, c, ctl[k], gs[k], gf[k], exp_ctl(k), ms[k], mf[k]);
            end
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (low0 != 1 || gs[0] !== 16'd1) begin
         bad++;
         $display("FAIL load_use_L1 got low=%0d stall_cnt=%0d exp low=1 stall_cnt=1", low0, gs[0]);
      end
   endtask

   task automatic test_gating();
      stim_t seq [6];
      seq = '{mk(0, 0, 0, 1, 0, 0, 0), mk(3, 7, 0, 1, 7, 0, 0), mk(3, 7, 1, 1, 7, 0, 0), '0, '0, '0};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cur = seq[c];
         @(negedge clk);
         if (c < 2) begin
            total++;
            if (ctl[0] !== 5'b11100) begin
               bad++;
               $display("FAIL gating_nostall cyc%0d got ctl=%b exp ctl=11100", c, ctl[0]);
            end
         end
         for (int k = 0; k < 3; k++) begin
            total++;
            if (ctl[k] !== exp_ctl(k) || gs[k] !== 16'(ms[k]) || gf[k] !== 16'(mf[k])) begin
               bad++;
               $display("FAIL gating dut%0d cyc%0d got ctl=%b s=%0d f=%0d exp ctl=%b s=%0d f=%0d",
                        k, c, ctl[k], gs[k], gf[k], exp_ctl(k), ms[k], mf[k]);
            end
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (gs[0] !== 16'd1) begin
         bad++;
         $display("FAIL gating_rs2 got stall_cnt=%0d exp stall_cnt=1", gs[0]);
      end
   endtask

   task automatic test_freeze_stall();
      stim_t seq [8];
      int    low3 = 0;
      seq = '{mk(5, 0, 0, 1, 5, 0, 0), mk(0, 0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 0, 1), '0, '0, '0, '0, '0};
      do_reset();
      for (int c = 0; c < 8; c++) begin
         cur = seq[c];
         @(negedge clk);
         if (ctl[1][4] == 1'b0) low3++;
         if (c == 1 || c == 2) begin
            total++;
            if (ctl[1] !== 5'b00000) begin
               bad++;
               $display("FAIL freeze_en cyc%0d got ctl=%b exp ctl=00000", c, ctl[1]);
            end
         end
         for (int k = 0; k < 3; k++) begin
            total++;
            if (ctl[k] !== exp_ctl(k) || gs[k] !== 16'(ms[k]) || gf[k] !== 16'(mf[k])) begin
               bad++;
               $display("FAIL freeze dut%0d cyc%0d got ctl=%b s=%0d f=%0d exp ctl=%b s=%0d f=%0d",
                        k, c, ctl[k], gs[k], gf[k], exp_ctl(k), ms[k], mf[k]);
            end
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (low3 != 5 || gs[1] !== 16'd5) begin
         bad++;
         $display("FAIL freeze_L3 got low=%0d stall_cnt=%0d exp low=5 stall_cnt=5", low3, gs[1]);
      end
   endtask

   task automatic test_branch_vs_hazard();
      do_reset();
      cur = mk(5, 0, 0, 1, 5, 1, 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (ctl[k] !== 5'b11111) begin
            bad++;
            $display("FAIL branch_hazard dut%0d got ctl=%b exp ctl=11111", k, ctl[k]);
         end
      end
      @(posedge clk);
      #1 cur = '0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (gf[k] !== 16'd1 || gs[k] !== 16'd0 || ctl[k] !== 5'b11100) begin
            bad++;
            $display("FAIL branch_cnt dut%0d got ctl=%b s=%0d f=%0d exp ctl=11100 s=0 f=1", k, ctl[k], gs[k], gf[k]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      cur = mk(5, 0, 0, 1, 5, 0, 0);
      @(posedge clk);
      #1 cur = '0;
      @(negedge clk);
      total++;
      if (ctl[1] !== 5'b00101) begin
         bad++;
         $display("FAIL rst_mid_pre got ctl=%b exp ctl=00101", ctl[1]);
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (ctl[k] !== 5'b00011 || gs[k] !== 16'd0 || gf[k] !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid dut%0d got ctl=%b s=%0d f=%0d exp ctl=00011 s=0 f=0", k, ctl[k], gs[k], gf[k]);
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (ctl[k] !== 5'b11100 || gs[k] !== 16'd0 || gf[k] !== 16'd0) begin
               bad++;
               $display("FAIL rst_after dut%0d cyc%0d got ctl=%b s=%0d f=%0d exp ctl=11100 s=0 f=0",
                        k, c, ctl[k], gs[k], gf[k]);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      cur = mk(0, 0, 0, 0, 0, 0, 1);
      repeat (20) @(posedge clk);
      #1 cur = '0;
      @(negedge clk);
      total++;
      if (gs[2] !== 16'd15 || gs[0] !== 16'd20) begin
         bad++;
         $display("FAIL saturation got s4=%0d s16=%0d exp s4=15 s16=20", gs[2], gs[0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         cur = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (ctl[k] !== exp_ctl(k) || gs[k] !== 16'(ms[k]) || gf[k] !== 16'(mf[k])) begin
               bad++;
               $display("FAIL random dut%0d cyc%0d got ctl=%b s=%0d f=%0d exp ctl=%b s=%0d f=%0d",
                        k, c, ctl[k], gs[k], gf[k], exp_ctl(k), ms[k], mf[k]);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_gating();
      test_freeze_stall();
      test_branch_vs_hazard();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
